// File: rtl/operand_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_if
// Description : Bundles the decode, memory read-port, writeback and execute
//               signals seen by the operand fetch stage. The slave modport
//               is the stage's view; the master modport is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_fetch_if #(
  parameter int ADRS_W = 11,
  parameter int DATA_W = 32,
  parameter int OPC_W  = 6
);
  // decode -> fetch
  logic              in_valid;
  logic              in_ready;
  logic [OPC_W-1:0]  in_opcode;
  logic [ADRS_W-1:0] in_src1;
  logic [ADRS_W-1:0] in_src2;
  logic              in_use1;
  logic              in_use2;
  logic [ADRS_W-1:0] in_dst;
  // fetch <-> memory read ports
  logic [ADRS_W-1:0] r_adrs1;
  logic [ADRS_W-1:0] r_adrs2;
  logic              r_en1;
  logic              r_en2;
  logic [DATA_W-1:0] data_out1;
  logic [DATA_W-1:0] data_out2;
  // writeback snoop
  logic              wb_w_en;
  logic [ADRS_W-1:0] wb_w_adrs;
  logic [DATA_W-1:0] wb_data;
  // fetch -> execute
  logic              out_valid;
  logic              out_ready;
  logic [OPC_W-1:0]  out_opcode;
  logic [DATA_W-1:0] out_op1;
  logic [DATA_W-1:0] out_op2;
  logic [ADRS_W-1:0] out_dst;

  modport slave (
    input  in_valid, in_opcode, in_src1, in_src2, in_use1, in_use2, in_dst,
    output in_ready,
    output r_adrs1, r_adrs2, r_en1, r_en2,
    input  data_out1, data_out2,
    input  wb_w_en, wb_w_adrs, wb_data,
    output out_valid, out_opcode, out_op1, out_op2, out_dst,
    input  out_ready
  );

  modport master (
    output in_valid, in_opcode, in_src1, in_src2, in_use1, in_use2, in_dst,
    input  in_ready,
    input  r_adrs1, r_adrs2, r_en1, r_en2,
    output data_out1, data_out2,
    output wb_w_en, wb_w_adrs, wb_data,
    input  out_valid, out_opcode, out_op1, out_op2, out_dst,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Operand fetch stage in front of a dual-read-port memory.
//               Issues reads for accepted instructions, holds in-flight
//               operands in a PEND slot (FRESH/HELD) and presents them from
//               a registered OUT slot. Writeback data is forwarded at issue
//               and snooped while pending to cover read-during-write.
//               Optional build macro OPF_ZERO_ADRS_EN: source address 0 is a
//               hardwired zero (no read, no bypass/snoop, operand = 0).
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
  parameter int ADRS_W = 11,
  parameter int DATA_W = 32,
  parameter int OPC_W  = 6
) (
  input  logic               clk,
  input  logic               resetn,
  operand_fetch_if.slave     bus
);

  typedef enum logic [1:0] {
    PEND_EMPTY = 2'd0,
    PEND_FRESH = 2'd1,
    PEND_HELD  = 2'd2
  } pend_state_e;

  pend_state_e       r_pend_state;
  logic [OPC_W-1:0]  r_pend_opcode;
  logic [ADRS_W-1:0] r_pend_dst;
  logic [ADRS_W-1:0] r_pend_src1;
  logic [ADRS_W-1:0] r_pend_src2;
  logic              r_pend_use1;
  logic              r_pend_use2;
  // r_have_k: r_val_k holds the operand (forwarded, snooped or latched)
  logic              r_have1;
  logic              r_have2;
  logic [DATA_W-1:0] r_val1;
  logic [DATA_W-1:0] r_val2;

  logic [ADRS_W-1:0] r_last_adrs1;
  logic [ADRS_W-1:0] r_last_adrs2;

  logic              r_out_valid;
  logic [OPC_W-1:0]  r_out_opcode;
  logic [DATA_W-1:0] r_out_op1;
  logic [DATA_W-1:0] r_out_op2;
  logic [ADRS_W-1:0] r_out_dst;

  logic              w_pend_valid;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_move;
  logic              w_zero1;
  logic              w_zero2;
  logic              w_iss_use1;
  logic              w_iss_use2;
  logic              w_byp1;
  logic              w_byp2;
  logic              w_snp1;
  logic              w_snp2;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;

`ifdef OPF_ZERO_ADRS_EN
  assign w_zero1 = (bus.in_src1 == '0);
  assign w_zero2 = (bus.in_src2 == '0);
`else
  assign w_zero1 = 1'b0;
  assign w_zero2 = 1'b0;
`endif

  // A zero-address operand is treated as unused, so it is never read,
  // bypassed or snooped and resolves to 0.
  assign w_iss_use1 = bus.in_use1 & ~w_zero1;
  assign w_iss_use2 = bus.in_use2 & ~w_zero2;

  assign w_pend_valid = (r_pend_state != PEND_EMPTY);
  assign w_in_ready   = ~w_pend_valid | ~r_out_valid | bus.out_ready;
  assign w_accept     = bus.in_valid & w_in_ready;
  assign w_move       = w_pend_valid & (~r_out_valid | bus.out_ready);

  // Memory returns old data on read-during-write, so a same-edge write to a
  // source is captured at issue.
  assign w_byp1 = bus.wb_w_en & (bus.wb_w_adrs == bus.in_src1) & w_iss_use1;
  assign w_byp2 = bus.wb_w_en & (bus.wb_w_adrs == bus.in_src2) & w_iss_use2;

  assign w_snp1 = w_pend_valid & bus.wb_w_en & (bus.wb_w_adrs == r_pend_src1) & r_pend_use1;
  assign w_snp2 = w_pend_valid & bus.wb_w_en & (bus.wb_w_adrs == r_pend_src2) & r_pend_use2;

  // A write landing on the move edge is newer than anything held, so it wins.
  assign w_op1 = !r_pend_use1 ? '0 :
                 w_snp1       ? bus.wb_data :
                 r_have1      ? r_val1 : bus.data_out1;
  assign w_op2 = !r_pend_use2 ? '0 :
                 w_snp2       ? bus.wb_data :
                 r_have2      ? r_val2 : bus.data_out2;

  assign bus.in_ready   = w_in_ready;
  assign bus.r_en1      = w_accept & w_iss_use1;
  assign bus.r_en2      = w_accept & w_iss_use2;
  assign bus.r_adrs1    = w_accept ? bus.in_src1 : r_last_adrs1;
  assign bus.r_adrs2    = w_accept ? bus.in_src2 : r_last_adrs2;

  assign bus.out_valid  = r_out_valid;
  assign bus.out_opcode = r_out_opcode;
  assign bus.out_op1    = r_out_op1;
  assign bus.out_op2    = r_out_op2;
  assign bus.out_dst    = r_out_dst;

  // Remember the last issued read addresses so the ports hold when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_adrs1 <= '0;
      r_last_adrs2 <= '0;
    end else if (w_accept) begin
      r_last_adrs1 <= bus.in_src1;
      r_last_adrs2 <= bus.in_src2;
    end
  end

  // PEND slot: load on accept, free on move, otherwise latch/snoop operands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend_state  <= PEND_EMPTY;
      r_pend_opcode <= '0;
      r_pend_dst    <= '0;
      r_pend_src1   <= '0;
      r_pend_src2   <= '0;
      r_pend_use1   <= 1'b0;
      r_pend_use2   <= 1'b0;
      r_have1       <= 1'b0;
      r_have2       <= 1'b0;
      r_val1        <= '0;
      r_val2        <= '0;
    end else if (w_accept) begin
      r_pend_state  <= PEND_FRESH;
      r_pend_opcode <= bus.in_opcode;
      r_pend_dst    <= bus.in_dst;
      r_pend_src1   <= bus.in_src1;
      r_pend_src2   <= bus.in_src2;
      r_pend_use1   <= w_iss_use1;
      r_pend_use2   <= w_iss_use2;
      r_have1       <= w_byp1;
      r_have2       <= w_byp2;
      r_val1        <= bus.wb_data;
      r_val2        <= bus.wb_data;
    end else if (w_move) begin
      r_pend_state  <= PEND_EMPTY;
    end else if (w_pend_valid) begin
      // Read data is only on data_out for one cycle; keep it from here on.
      r_pend_state <= PEND_HELD;
      r_have1      <= 1'b1;
      r_have2      <= 1'b1;
      if (w_snp1) begin
        r_val1 <= bus.wb_data;
      end else if (!r_have1) begin
        r_val1 <= bus.data_out1;
      end
      if (w_snp2) begin
        r_val2 <= bus.wb_data;
      end else if (!r_have2) begin
        r_val2 <= bus.data_out2;
      end
    end
  end

  // OUT slot: take PEND when it moves, drop valid when consumed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid  <= 1'b0;
      r_out_opcode <= '0;
      r_out_op1    <= '0;
      r_out_op2    <= '0;
      r_out_dst    <= '0;
    end else if (w_move) begin
      r_out_valid  <= 1'b1;
      r_out_opcode <= r_pend_opcode;
      r_out_op1    <= w_op1;
      r_out_op2    <= w_op2;
      r_out_dst    <= r_pend_dst;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Directed self-checking bench for operand_fetch with a small
//               dual-read-port memory model (junk data when not read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;
  localparam int ADRS_W = 11;
  localparam int DATA_W = 32;
  localparam int OPC_W  = 6;
  localparam logic [DATA_W-1:0] c_junk1 = 32'hBAD0_BAD1;
  localparam logic [DATA_W-1:0] c_junk2 = 32'hBAD0_BAD2;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [DATA_W-1:0] mem [0:(1<<ADRS_W)-1];

  always #5 clk = ~clk;

  operand_fetch_if #(.ADRS_W(ADRS_W), .DATA_W(DATA_W), .OPC_W(OPC_W)) bus ();

  operand_fetch #(.ADRS_W(ADRS_W), .DATA_W(DATA_W), .OPC_W(OPC_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Memory model: registered read, old data on read-during-write.
  always @(posedge clk) begin
    bus.data_out1 <= bus.r_en1 ? mem[bus.r_adrs1] : c_junk1;
    bus.data_out2 <= bus.r_en2 ? mem[bus.r_adrs2] : c_junk2;
    if (bus.wb_w_en) mem[bus.wb_w_adrs] <= bus.wb_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [OPC_W-1:0] opc,
                       input logic [ADRS_W-1:0] s1, input logic [ADRS_W-1:0] s2,
                       input logic u1, input logic u2, input logic [ADRS_W-1:0] dst);
    bus.in_valid  = v;
    bus.in_opcode = opc;
    bus.in_src1   = s1;
    bus.in_src2   = s2;
    bus.in_use1   = u1;
    bus.in_use2   = u2;
    bus.in_dst    = dst;
  endtask

  task automatic mem_write(input logic [ADRS_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wb_w_en   = 1'b1;
    bus.wb_w_adrs = a;
    bus.wb_data   = d;
    tick();
    bus.wb_w_en   = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_zr_en;
    logic [31:0] exp_zr_op;
`ifdef OPF_ZERO_ADRS_EN
    exp_zr_en = 32'd0;
    exp_zr_op = 32'd0;
`else
    exp_zr_en = 32'd1;
    exp_zr_op = 32'h55;
`endif
    resetn        = 1'b0;
    bus.out_ready = 1'b1;
    bus.wb_w_en   = 1'b0;
    bus.wb_w_adrs = '0;
    bus.wb_data   = '0;
    issue(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_r_en1", bus.r_en1, 0);
    check("rst_out_op1", bus.out_op1, 0);
    resetn = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    tick();

    mem_write(11'h045, 32'h1A4);
    mem_write(11'h001, 32'hF);
    mem_write(11'h7FF, 32'h0);
    mem_write(11'h7FE, 32'h11);
    mem_write(11'h000, 32'h55);
    tick();

    // Back-to-back: three instructions, three consecutive outputs
    issue(1'b1, 6'h01, 11'h045, 11'h001, 1'b1, 1'b1, 11'h010);
    #1;
    check("b2b_r_en1", bus.r_en1, 1);
    check("b2b_r_en2", bus.r_en2, 1);
    check("b2b_r_adrs1", bus.r_adrs1, 32'h45);
    check("b2b_r_adrs2", bus.r_adrs2, 32'h01);
    tick();
    check("b2b_lat_valid", bus.out_valid, 0);
    issue(1'b1, 6'h02, 11'h001, 11'h045, 1'b1, 1'b1, 11'h011);
    tick();
    check("b2b_a_valid", bus.out_valid, 1);
    check("b2b_a_op1", bus.out_op1, 32'h1A4);
    check("b2b_a_op2", bus.out_op2, 32'hF);
    check("b2b_a_opc", bus.out_opcode, 32'h01);
    check("b2b_a_dst", bus.out_dst, 32'h010);
    issue(1'b1, 6'h03, 11'h045, 11'h001, 1'b1, 1'b0, 11'h012);
    #1;
    check("unused_r_en2", bus.r_en2, 0);
    tick();
    check("b2b_b_valid", bus.out_valid, 1);
    check("b2b_b_op1", bus.out_op1, 32'hF);
    check("b2b_b_op2", bus.out_op2, 32'h1A4);
    check("b2b_b_opc", bus.out_opcode, 32'h02);
    issue(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    check("idle_r_en1", bus.r_en1, 0);
    check("idle_r_adrs1_hold", bus.r_adrs1, 32'h45);
    tick();
    check("b2b_c_valid", bus.out_valid, 1);
    check("b2b_c_op1", bus.out_op1, 32'h1A4);
    check("unused_op2", bus.out_op2, 32'h0);
    check("b2b_c_opc", bus.out_opcode, 32'h03);
    tick();
    check("b2b_drain_valid", bus.out_valid, 0);

    // Stall/skid with out_ready low
    bus.out_ready = 1'b0;
    issue(1'b1, 6'h04, 11'h045, 11'h001, 1'b1, 1'b1, 11'h020);
    tick();
    issue(1'b1, 6'h05, 11'h001, 11'h045, 1'b1, 1'b1, 11'h021);
    #1;
    check("stall_in_ready_2nd", bus.in_ready, 1);
    tick();
    check("stall_d_valid", bus.out_valid, 1);
    issue(1'b1, 6'h06, 11'h045, 11'h045, 1'b1, 1'b1, 11'h022);
    #1;
    check("stall_full_in_ready", bus.in_ready, 0);
    check("stall_full_r_en1", bus.r_en1, 0);
    tick();
    tick();
    tick();
    check("stall_d_stable_opc", bus.out_opcode, 32'h04);
    check("stall_d_stable_op1", bus.out_op1, 32'h1A4);
    check("stall_d_stable_op2", bus.out_op2, 32'hF);
    issue(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    bus.out_ready = 1'b1;
    tick();
    check("stall_e_valid", bus.out_valid, 1);
    check("stall_e_opc", bus.out_opcode, 32'h05);
    check("stall_e_held_op1", bus.out_op1, 32'hF);
    check("stall_e_held_op2", bus.out_op2, 32'h1A4);
    check("stall_e_dst", bus.out_dst, 32'h021);
    tick();
    check("stall_drain_valid", bus.out_valid, 0);

    // Issue-edge bypass from writeback
    issue(1'b1, 6'h07, 11'h7FF, 11'h000, 1'b1, 1'b0, 11'h030);
    bus.wb_w_en   = 1'b1;
    bus.wb_w_adrs = 11'h7FF;
    bus.wb_data   = 32'hDEADBEEF;
    tick();
    bus.wb_w_en = 1'b0;
    issue(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    check("byp_valid", bus.out_valid, 1);
    check("byp_op1", bus.out_op1, 32'hDEADBEEF);
    check("byp_op2", bus.out_op2, 32'h0);
    tick();

    // Snoop into a HELD pending operand
    bus.out_ready = 1'b0;
    issue(1'b1, 6'h08, 11'h045, 11'h000, 1'b1, 1'b0, 11'h040);
    tick();
    issue(1'b1, 6'h09, 11'h000, 11'h7FE, 1'b0, 1'b1, 11'h041);
    tick();
    issue(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    bus.wb_w_en   = 1'b1;
    bus.wb_w_adrs = 11'h7FE;
    bus.wb_data   = 32'h12345678;
    tick();
    bus.wb_w_en = 1'b0;
    check("snp_g_opc", bus.out_opcode, 32'h08);
    check("snp_g_op1", bus.out_op1, 32'h1A4);
    bus.out_ready = 1'b1;
    tick();
    check("snp_h_opc", bus.out_opcode, 32'h09);
    check("snp_h_op2", bus.out_op2, 32'h12345678);
    check("snp_h_op1", bus.out_op1, 32'h0);
    tick();

    // Address zero: ordinary location or hardwired zero
    issue(1'b1, 6'h0A, 11'h000, 11'h001, 1'b1, 1'b1, 11'h050);
    #1;
    check("zero_r_en1", bus.r_en1, exp_zr_en);
    check("zero_r_en2", bus.r_en2, 1);
    tick();
    issue(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    check("zero_op1", bus.out_op1, exp_zr_op);
    check("zero_op2", bus.out_op2, 32'hF);
    tick();

    // Reset asserted with PEND and OUT both occupied
    bus.out_ready = 1'b0;
    issue(1'b1, 6'h0B, 11'h045, 11'h001, 1'b1, 1'b1, 11'h060);
    tick();
    issue(1'b1, 6'h0C, 11'h001, 11'h045, 1'b1, 1'b1, 11'h061);
    tick();
    issue(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    check("mid_full_in_ready", bus.in_ready, 0);
    check("mid_pre_valid", bus.out_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_op1", bus.out_op1, 0);
    check("mid_rst_opc", bus.out_opcode, 0);
    check("mid_rst_dst", bus.out_dst, 0);
    #3;
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("mid_rel_in_ready", bus.in_ready, 1);
    tick();
    check("mid_no_stale_1", bus.out_valid, 0);
    tick();
    check("mid_no_stale_2", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
